// File: rtl/bf4_stream.sv
// Streaming 4-point DFT butterfly: collects four samples, computes all bins in
// one cycle into a result bank, then emits the bins serially as 0..3.
module bf4_stream #(
  parameter int IW         = 14,
  parameter int OW         = 16,
  parameter int CPLX       = 0,
  parameter int SCALE_MODE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_re,
  input  logic [IW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_re,
  output logic [OW-1:0] out_im,
  output logic [1:0]    out_idx,
  output logic          out_last
);

  localparam int W = IW + 2;

  // Handshake: a beat moves on a rising edge where valid && ready are both high.
  // A producer holds its data stable while valid && !ready; out_* obey the same rule.

  logic signed [IW-1:0] xr [4];
  logic signed [IW-1:0] xi [4];
  logic [2:0]           in_count;
  logic signed [OW-1:0] bank_re [4];
  logic signed [OW-1:0] bank_im [4];
  logic                 bank_full;
  logic [1:0]           idx;

  logic draining, transfer, accept;

  assign draining  = bank_full && out_ready && (idx == 2'd3);
  assign transfer  = (in_count == 3'd4) && (!bank_full || draining);
  assign in_ready  = (in_count < 3'd4) || transfer;
  assign accept    = in_valid && in_ready;

  assign out_valid = bank_full;
  assign out_idx   = idx;
  assign out_last  = bank_full && (idx == 2'd3);
  assign out_re    = bank_re[idx];
  assign out_im    = bank_im[idx];

  function automatic int shift_of(input int k);
    case (SCALE_MODE)
      0:       return 0;
      2:       return 2;
      default: return ((k % 2) == 0) ? 2 : 1;
    endcase
  endfunction

  // Negative values get a half-LSB bias so they round toward zero on ties.
  function automatic logic signed [W-1:0] rnd(input logic signed [W-1:0] v, input int s);
    logic signed [W-1:0] bias;
    bias = (s > 0 && v < 0) ? (W'(1) <<< (s - 1)) : '0;
    return (v + bias) >>> s;
  endfunction

  logic signed [W-1:0]  a [4];
  logic signed [W-1:0]  b [4];
  logic signed [W-1:0]  br [4];
  logic signed [W-1:0]  bi [4];
  logic signed [W-1:0]  s02a, d02a, s13a, d13a, s02b, d02b, s13b, d13b;
  logic signed [OW-1:0] nr [4];
  logic signed [OW-1:0] ni [4];

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      a[n] = W'(xr[n]);
      b[n] = (CPLX != 0) ? W'(xi[n]) : '0;
    end
    s02a = a[0] + a[2];
    d02a = a[0] - a[2];
    s13a = a[1] + a[3];
    d13a = a[1] - a[3];
    s02b = b[0] + b[2];
    d02b = b[0] - b[2];
    s13b = b[1] + b[3];
    d13b = b[1] - b[3];
    br[0] = s02a + s13a;
    bi[0] = s02b + s13b;
    br[1] = d02a + d13b;
    bi[1] = d02b - d13a;
    br[2] = s02a - s13a;
    bi[2] = s02b - s13b;
    br[3] = d02a - d13b;
    bi[3] = d02b + d13a;
    for (int k = 0; k < 4; k++) begin
      nr[k] = OW'(rnd(br[k], shift_of(k)));
      ni[k] = OW'(rnd(bi[k], shift_of(k)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_count  <= '0;
      bank_full <= 1'b0;
      idx       <= '0;
      for (int n = 0; n < 4; n++) begin
        xr[n]      <= '0;
        xi[n]      <= '0;
        bank_re[n] <= '0;
        bank_im[n] <= '0;
      end
    end else begin
      // A sample taken during a transfer starts the next frame as x0.
      if (transfer)
        in_count <= accept ? 3'd1 : 3'd0;
      else if (accept)
        in_count <= in_count + 3'd1;

      if (accept) begin
        xr[transfer ? 2'd0 : in_count[1:0]] <= in_re;
        xi[transfer ? 2'd0 : in_count[1:0]] <= in_im;
      end

      if (transfer) begin
        for (int k = 0; k < 4; k++) begin
          bank_re[k] <= nr[k];
          bank_im[k] <= ni[k];
        end
        bank_full <= 1'b1;
        idx       <= '0;
      end else if (bank_full && out_ready) begin
        if (idx == 2'd3) begin
          bank_full <= 1'b0;
          idx       <= '0;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: doc/bf4_stream.md
Name: bf4_stream

Overview:
Streaming radix-4 (4-point DFT) butterfly engine, the parametrised successor of the team's combinational 4-point real-input butterfly. Samples arrive serially over a valid/ready interface, four to a frame, and are collected into an input bank. Results are double-buffered into a result bank and emitted serially as bins 0..3. Supports real or complex input and selectable output scaling with the team's sign-dependent rounding. Sits between the sample source and downstream FFT stages or magnitude logic.

Parameters:
IW, 14, input sample width (signed, two's complement)
OW, 16, output width (signed); OW >= IW+2 required for all modes
CPLX, 0, 0 = real input (in_im ignored, treated as 0); 1 = complex input
SCALE_MODE, 1, 0 = no scaling (full growth); 1 = legacy per-bin (bins 0,2 divided by 4; bins 1,3 divided by 2); 2 = uniform divide-by-4 on all bins

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_re  in  IW  sample real part
in_im  in  IW  sample imaginary part (unused when CPLX=0)
out_valid  out  1  output bin valid
out_ready  in  1  downstream accepts bin
out_re  out  OW  bin real part
out_im  out  OW  bin imaginary part
out_idx  out  2  bin index 0..3
out_last  out  1  high with bin 3

Behaviour:
- Reset is asynchronous on rst_n low and clears all state. In reset: in_count=0, the result bank is empty, out_valid=0, out_idx=0, out_last=0, out_re=0, out_im=0, in_ready=1 after release.
- Reset mid-frame discards partially collected samples and any undelivered bins. The first sample accepted after release is x0.
- Input accept: a sample is accepted when in_valid && in_ready. It is stored as x[in_count], and in_count increments 0..4.
- Transfer occurs when in_count==4 && (bank empty || bank draining), where bank draining = out_valid && out_ready && out_idx==3. On transfer, all four bins are computed and registered into the bank, and in_count resets to 0.
- in_ready = (in_count<4) || transfer. A sample accepted in a transfer cycle becomes x0 of the next frame, with in_count set to 1.
- Latency: the 4th sample is accepted at edge E. If the bank is free, the transfer happens at edge E+1, and out_valid, out_idx=0 and bin 0 are visible after E+1.
- With out_ready held at 1, throughput is one sample per cycle in and one bin per cycle out, sustained with no bubbles.
- Output: bins are emitted in order 0,1,2,3. The bin advances only when out_valid && out_ready. out_re, out_im and out_idx must remain stable while out_valid && !out_ready. After bin 3 is taken, out_valid drops unless a transfer occurs in the same cycle, in which case bin 0 of the new frame follows immediately.
- Arithmetic: xk = ak + j*bk, with bk = 0 when CPLX=0. Intermediates are computed at IW+2 bits, sign-extended.
  X0 = (a0+a1+a2+a3) + j(b0+b1+b2+b3)
  X1 = ((a0-a2)+(b1-b3)) + j((b0-b2)-(a1-a3))
  X2 = (a0-a1+a2-a3) + j(b0-b1+b2-b3)
  X3 = ((a0-a2)-(b1-b3)) + j((b0-b2)+(a1-a3))
- Scaling R(v,s): if v>=0, v>>>s; if v<0, (v+2^(s-1))>>>s. When s=0, R(v,0)=v. R is applied to re and im independently, and the result is sign-extended to OW. No saturation is needed.
- Shift s per mode: mode 0 uses s=0 for all bins; mode 1 uses s=2 for bins 0,2 and s=1 for bins 1,3; mode 2 uses s=2 for all bins.
- CPLX=0 consequences: out_im for bins 0 and 2 is exactly 0. Bin 1 im = R(a3-a1). Bin 3 im = R(a1-a3).
- When in_valid is low, no state changes on the input side. When in_count==4 and the bank is full and not draining, in_ready=0 and the frame is held.

Test Plan:
- CPLX=0, mode 1: inputs 100,20,-30,4 -> bins (23,0),(65,-8),(11,0),(65,8), with out_last only on bin 3.
- CPLX=0, mode 1, negative rounding: inputs -6,0,0,0 -> bins (-1,0),(-3,0),(-1,0),(-3,0).
- CPLX=1, mode 2: inputs (8,4),(4,0),(0,0),(0,-4) -> bins (3,0),(3,0),(1,2),(1,2).
- CPLX=0, mode 0, IW=14/OW=16: four samples of -8192 -> bin 0 re = -32768, with all other bins 0 and no overflow.
- Streaming/backpressure: 3 back-to-back frames at in_valid=1 with out_ready toggling 1,0,0,1 -> outputs held stable while stalled, in_ready drops only when a frame is full and the bank is undrained, no sample is lost or duplicated, and with out_ready=1 throughout there are 12 outputs in 12 consecutive cycles.
- Reset: assert rst_n low after 2 samples and during bin 1 output -> out_valid=0 immediately. After release, a fresh 4-sample frame produces correct bins with out_idx starting at 0.
